// File: rtl/vote_pkg.sv
// Shared types and default parameters for the voting-machine button front end.
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    LATCHED = 2'd2,
    RELEASE = 2'd3
  } btn_state_e;

  localparam int NUM_BUTTONS_DEF    = 4;
  localparam int HOLD_CYCLES_DEF    = 10;
  localparam int RELEASE_CYCLES_DEF = 2;

endpackage

// File: rtl/vote_button_conditioner_if.sv
// Button/vote bundle between the button panel (master) and the conditioner (slave).
interface vote_button_conditioner_if
  import vote_pkg::*;
#(
  parameter int NUM_BUTTONS = NUM_BUTTONS_DEF
);
  logic                   mode;
  logic [NUM_BUTTONS-1:0] button;
  logic [NUM_BUTTONS-1:0] vote_pulse;
  logic                   conflict;
  logic [NUM_BUTTONS-1:0] busy;

  modport master (output mode, button, input vote_pulse, conflict, busy);
  modport slave  (input mode, button, output vote_pulse, conflict, busy);
endinterface

// File: rtl/vote_button_channel.sv
// One button channel: two-flop synchronizer, press qualifier and release re-arm.
// o_qualify fires on the edge the hold count completes; the top decides via i_force_latch.
module vote_button_channel
  import vote_pkg::*;
#(
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_button,
  input  logic       i_force_latch,
  output logic       o_qualify,
  output btn_state_e o_state
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REL_LAST  = RW'(RELEASE_CYCLES - 1);

  logic          r_sync1;
  logic          r_btn_s;
  btn_state_e    r_state;
  btn_state_e    w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;
  logic [RW-1:0] r_rcnt;
  logic [RW-1:0] w_next_rcnt;
  logic          w_hold_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rcnt  <= '0;
    end else begin
      r_sync1 <= i_button;
      r_btn_s <= r_sync1;
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_rcnt  <= w_next_rcnt;
    end
  end

  // The hold is complete on the edge that would bring cnt up to HOLD_CYCLES.
  assign w_hold_done = r_btn_s &&
                       (((r_state == IDLE) && (HOLD_CYCLES == 1)) ||
                        ((r_state == COUNT) && (r_cnt >= HOLD_LAST)));

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_rcnt  = r_rcnt;
    case (r_state)
      IDLE: begin
        if (r_btn_s) begin
          if (w_hold_done && i_force_latch) begin
            w_next_state = LATCHED;
          end else begin
            w_next_state = COUNT;
            w_next_cnt   = CW'(1);
          end
        end
      end
      COUNT: begin
        if (!r_btn_s) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end else if (w_hold_done) begin
          if (i_force_latch) begin
            w_next_state = LATCHED;
            w_next_cnt   = '0;
          end
        end else begin
          w_next_cnt = r_cnt + CW'(1);
        end
      end
      LATCHED: begin
        if (!r_btn_s) begin
          if (RELEASE_CYCLES == 1) begin
            w_next_state = IDLE;
          end else begin
            w_next_state = RELEASE;
            w_next_rcnt  = RW'(1);
          end
        end
      end
      RELEASE: begin
        if (r_btn_s) begin
          w_next_state = LATCHED;
          w_next_rcnt  = '0;
        end else if (r_rcnt >= REL_LAST) begin
          w_next_state = IDLE;
          w_next_rcnt  = '0;
        end else begin
          w_next_rcnt = r_rcnt + RW'(1);
        end
      end
    endcase
  end

  assign o_qualify = w_hold_done;
  assign o_state   = r_state;

endmodule

// File: rtl/vote_button_conditioner.sv
// Four-button vote front end: per-channel debounce plus overlap/mode arbitration,
// producing one registered one-hot vote pulse per deliberate press.
module vote_button_conditioner
  import vote_pkg::*;
#(
  parameter int NUM_BUTTONS    = NUM_BUTTONS_DEF,
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
  input logic                      clock,
  input logic                      reset,
  vote_button_conditioner_if.slave bus
);
  logic [NUM_BUTTONS-1:0] w_qualify;
  logic [NUM_BUTTONS-1:0] w_active;
  btn_state_e             w_state [NUM_BUTTONS];
  logic                   w_multi;
  logic                   w_others;
  logic                   w_accept;
  logic                   w_conflict;
  logic [NUM_BUTTONS-1:0] w_vote;
  logic [NUM_BUTTONS-1:0] r_vote_pulse;
  logic                   r_conflict;
  logic [NUM_BUTTONS-1:0] r_busy;

  // Every qualifying channel latches whatever the arbitration outcome.
  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_channel
    vote_button_channel #(
      .HOLD_CYCLES    (HOLD_CYCLES),
      .RELEASE_CYCLES (RELEASE_CYCLES)
    ) u_channel (
      .clock         (clock),
      .reset         (reset),
      .i_button      (bus.button[g]),
      .i_force_latch (w_qualify[g]),
      .o_qualify     (w_qualify[g]),
      .o_state       (w_state[g])
    );
    assign w_active[g] = (w_state[g] != IDLE);
  end

  assign w_multi    = (w_qualify & (w_qualify - 1'b1)) != '0;
  assign w_others   = |(w_active & ~w_qualify);
  assign w_accept   = (|w_qualify) && !bus.mode && !w_multi && !w_others;
  assign w_conflict = (|w_qualify) && !bus.mode && (w_multi || w_others);
  assign w_vote     = w_accept ? w_qualify : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_vote_pulse <= '0;
      r_conflict   <= 1'b0;
      r_busy       <= '0;
    end else begin
      r_vote_pulse <= w_vote;
      r_conflict   <= w_conflict;
      r_busy       <= w_active;
    end
  end

  assign bus.vote_pulse = r_vote_pulse;
  assign bus.conflict   = r_conflict;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_vote_button_conditioner.sv
// Bench for vote_button_conditioner: directed press scenarios plus random button
// traffic, every cycle compared against a press/release reference model.
module tb_vote_button_conditioner;
  localparam int NB   = 4;
  localparam int HOLD = 10;
  localparam int REL  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  vote_button_conditioner_if #(.NUM_BUTTONS(NB)) vif ();

  vote_button_conditioner #(
    .NUM_BUTTONS    (NB),
    .HOLD_CYCLES    (HOLD),
    .RELEASE_CYCLES (REL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clock = ~clock;

  int checkCount = 0;
  int passCount  = 0;
  int pulseCount = 0;
  int conflictCount = 0;
  logic [NB-1:0] lastPulse = '0;

  int highRun [NB];
  int lowRun  [NB];
  bit armed   [NB];
  logic [NB-1:0] ms1 = '0;
  logic [NB-1:0] ms2 = '0;
  logic [NB-1:0] expPulse = '0;
  logic [NB-1:0] expBusy  = '0;
  logic          expConflict = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                  tag, observed, expected, $time);
  endtask

  task automatic applyStimulus(input logic [NB-1:0] btn, input logic md, input int cycles);
    vif.button = btn;
    vif.mode   = md;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic clearTally();
    pulseCount    = 0;
    conflictCount = 0;
    lastPulse     = '0;
  endtask

  // Reference model: a button votes when it has been seen high for HOLD
  // consecutive synchronised samples while armed; it re-arms after REL lows.
  always @(posedge clock) begin : model
    logic [NB-1:0] s;
    logic [NB-1:0] quals;
    logic [NB-1:0] preBusy;
    int nq;
    if (reset) begin
      for (int c = 0; c < NB; c++) begin
        highRun[c] = 0;
        lowRun[c]  = 0;
        armed[c]   = 1'b1;
      end
      ms1 = '0;
      ms2 = '0;
      expPulse = '0;
      expConflict = 1'b0;
      expBusy = '0;
    end else begin
      s = ms2;
      ms2 = ms1;
      ms1 = vif.button;
      quals = '0;
      nq = 0;
      for (int c = 0; c < NB; c++) preBusy[c] = !armed[c] || (highRun[c] > 0);
      for (int c = 0; c < NB; c++) begin
        if (s[c]) begin
          if (highRun[c] < 1000) highRun[c]++;
          lowRun[c] = 0;
        end else begin
          highRun[c] = 0;
          if (lowRun[c] < 1000) lowRun[c]++;
        end
        if (armed[c] && s[c] && highRun[c] == HOLD) begin
          quals[c] = 1'b1;
          nq++;
          armed[c] = 1'b0;
        end else if (!armed[c] && lowRun[c] >= REL) begin
          armed[c] = 1'b1;
        end
      end
      expPulse = '0;
      expConflict = 1'b0;
      if (nq > 0 && !vif.mode) begin
        if (nq > 1 || (preBusy & ~quals) != '0) expConflict = 1'b1;
        else expPulse = quals;
      end
      expBusy = preBusy;
    end
    #1;
    checkOutput("vote_pulse", 32'(vif.vote_pulse), 32'(expPulse));
    checkOutput("conflict", 32'(vif.conflict), 32'(expConflict));
    checkOutput("busy", 32'(vif.busy), 32'(expBusy));
    if (vif.vote_pulse != '0) begin
      pulseCount++;
      lastPulse = vif.vote_pulse;
    end
    if (vif.conflict) conflictCount++;
  end

  initial begin
    logic [NB-1:0] btn;
    logic md;
    vif.button = '0;
    vif.mode   = 1'b0;
    reset      = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b0;

    $display("[TB] single press held");
    clearTally();
    applyStimulus(4'b0001, 1'b0, 20);
    applyStimulus(4'b0000, 1'b0, 10);
    checkOutput("t1 votes", pulseCount, 32'd1);
    checkOutput("t1 channel", 32'(lastPulse), 32'h1);
    checkOutput("t1 busy idle", 32'(vif.busy), 32'h0);

    $display("[TB] short glitch");
    clearTally();
    applyStimulus(4'b0001, 1'b0, 5);
    applyStimulus(4'b0000, 1'b0, 10);
    checkOutput("t2 votes", pulseCount, 32'd0);
    checkOutput("t2 conflicts", conflictCount, 32'd0);
    checkOutput("t2 busy idle", 32'(vif.busy), 32'h0);

    $display("[TB] simultaneous presses");
    clearTally();
    applyStimulus(4'b0110, 1'b0, 20);
    applyStimulus(4'b0000, 1'b0, 10);
    checkOutput("t3 votes", pulseCount, 32'd0);
    checkOutput("t3 conflicts", conflictCount, 32'd1);
    clearTally();
    applyStimulus(4'b0100, 1'b0, 20);
    applyStimulus(4'b0000, 1'b0, 10);
    checkOutput("t3 revote", pulseCount, 32'd1);
    checkOutput("t3 channel", 32'(lastPulse), 32'h4);

    $display("[TB] result display mode");
    clearTally();
    applyStimulus(4'b0010, 1'b1, 20);
    applyStimulus(4'b0010, 1'b0, 15);
    applyStimulus(4'b0000, 1'b0, 10);
    checkOutput("t4 suppressed", pulseCount, 32'd0);
    checkOutput("t4 conflicts", conflictCount, 32'd0);
    clearTally();
    applyStimulus(4'b0010, 1'b0, 20);
    applyStimulus(4'b0000, 1'b0, 10);
    checkOutput("t4 repress", pulseCount, 32'd1);
    checkOutput("t4 channel", 32'(lastPulse), 32'h2);

    $display("[TB] release bounce");
    clearTally();
    applyStimulus(4'b0001, 1'b0, 20);
    applyStimulus(4'b0000, 1'b0, 1);
    applyStimulus(4'b0001, 1'b0, 1);
    applyStimulus(4'b0000, 1'b0, 10);
    checkOutput("t5 bounce", pulseCount, 32'd1);
    applyStimulus(4'b0001, 1'b0, 20);
    applyStimulus(4'b0000, 1'b0, 10);
    checkOutput("t5 second vote", pulseCount, 32'd2);

    $display("[TB] reset mid-press");
    clearTally();
    applyStimulus(4'b1000, 1'b0, 6);
    reset = 1'b1;
    applyStimulus(4'b1000, 1'b0, 1);
    reset = 1'b0;
    applyStimulus(4'b1000, 1'b0, 20);
    applyStimulus(4'b0000, 1'b0, 10);
    checkOutput("t6 votes", pulseCount, 32'd1);
    checkOutput("t6 channel", 32'(lastPulse), 32'h8);

    $display("[TB] random traffic");
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: btn = NB'(1) << $urandom_range(0, NB - 1);
        5, 6:          btn = '0;
        default:       btn = NB'($urandom_range(0, 15));
      endcase
      md = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        applyStimulus(btn, md, 1);
        reset = 1'b0;
      end
      applyStimulus(btn, md, $urandom_range(1, 24));
    end
    applyStimulus(4'b0000, 1'b0, 10);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
